// File: rtl/wfr_axi_arbiter_pkg.sv
// Shared state encoding and AXI response codes for the waveform-recorder write arbiter.
package wfr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } arbStateT;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/wfr_axi_arbiter_if.sv
// AXI4 write-channel bundle: per-recorder upstream ports (s_*) plus the shared DDR port (m_*).
interface wfr_axi_arbiter_if #(
    parameter int NUM_MASTERS    = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 128
);

    logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] s_AWADDR;
    logic [NUM_MASTERS*8-1:0]              s_AWLEN;
    logic [NUM_MASTERS-1:0]                s_AWVALID;
    logic [NUM_MASTERS-1:0]                s_AWREADY;
    logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0] s_WDATA;
    logic [NUM_MASTERS-1:0]                s_WLAST;
    logic [NUM_MASTERS-1:0]                s_WVALID;
    logic [NUM_MASTERS-1:0]                s_WREADY;
    logic [2*NUM_MASTERS-1:0]              s_BRESP;
    logic [NUM_MASTERS-1:0]                s_BVALID;

    logic [AXI_ADDR_WIDTH-1:0]             m_AWADDR;
    logic [7:0]                            m_AWLEN;
    logic                                  m_AWVALID;
    logic                                  m_AWREADY;
    logic [AXI_DATA_WIDTH-1:0]             m_WDATA;
    logic                                  m_WLAST;
    logic                                  m_WVALID;
    logic                                  m_WREADY;
    logic [1:0]                            m_BRESP;
    logic                                  m_BVALID;
    logic                                  m_BREADY;

    // Arbiter view: slave to the recorders, master toward DDR.
    modport slave (
        input  s_AWADDR, s_AWLEN, s_AWVALID, s_WDATA, s_WLAST, s_WVALID,
        input  m_AWREADY, m_WREADY, m_BRESP, m_BVALID,
        output s_AWREADY, s_WREADY, s_BRESP, s_BVALID,
        output m_AWADDR, m_AWLEN, m_AWVALID, m_WDATA, m_WLAST, m_WVALID, m_BREADY
    );

    modport master (
        output s_AWADDR, s_AWLEN, s_AWVALID, s_WDATA, s_WLAST, s_WVALID,
        output m_AWREADY, m_WREADY, m_BRESP, m_BVALID,
        input  s_AWREADY, s_WREADY, s_BRESP, s_BVALID,
        input  m_AWADDR, m_AWLEN, m_AWVALID, m_WDATA, m_WLAST, m_WVALID, m_BREADY
    );

endinterface

// File: rtl/wfr_axi_arbiter_rr_picker.sv
// Combinational round-robin picker: selects the first requester after lastIdx in circular order.
module wfr_rr_picker #(
    parameter  int NUM_MASTERS = 4,
    localparam int IdxW        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IdxW-1:0]        lastIdx,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [IdxW-1:0]        idx
);

    always_comb begin
        int        cand;
        logic [IdxW-1:0] candIdx;
        logic      found;
        gnt     = '0;
        idx     = '0;
        found   = 1'b0;
        cand    = 0;
        candIdx = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand    = (int'(lastIdx) + k) % NUM_MASTERS;
            candIdx = IdxW'(cand);
            if (!found && req[candIdx]) begin
                found        = 1'b1;
                gnt[candIdx] = 1'b1;
                idx          = candIdx;
            end
        end
    end

endmodule

// File: rtl/wfr_axi_arbiter.sv
// Burst-granular round-robin arbiter sharing one AXI4 write port among NUM_MASTERS recorders.
// Define WFR_ARB_TIMEOUT_EN to enable the B-response watchdog and sticky timeout flag.
module wfr_axi_arbiter
    import wfr_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wfr_axi_arbiter_if.slave       bus,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   timeout
);

    // state | meaning
    // IDLE  | no owner; pick next requester round-robin after lastIdx
    // ADDR  | owner's AW forwarded until m_AWVALID & m_AWREADY
    // DATA  | owner's W forwarded until the WLAST beat handshakes
    // RESP  | m_BREADY high; owner gets B, then release to IDLE

    localparam int IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    arbStateT               state, stateNxt;
    logic [IdxW-1:0]        owner, lastIdx, pickIdx;
    logic [NUM_MASTERS-1:0] pickGnt;
    logic                   respDone;
    logic                   tmrExpired;

    wfr_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) uPicker (
        .req     (bus.s_AWVALID),
        .lastIdx (lastIdx),
        .gnt     (pickGnt),
        .idx     (pickIdx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= '0;
            lastIdx <= IdxW'(NUM_MASTERS - 1);
        end else begin
            state <= stateNxt;
            if (state == IDLE && |pickGnt) owner <= pickIdx;
            if (respDone) lastIdx <= owner;
        end
    end

    always_comb begin
        stateNxt       = state;
        respDone       = 1'b0;
        grant          = '0;
        bus.s_AWREADY  = '0;
        bus.s_WREADY   = '0;
        bus.s_BVALID   = '0;
        bus.s_BRESP    = {NUM_MASTERS{OKAY}};
        bus.m_AWADDR   = '0;
        bus.m_AWLEN    = '0;
        bus.m_AWVALID  = 1'b0;
        bus.m_WDATA    = '0;
        bus.m_WLAST    = 1'b0;
        bus.m_WVALID   = 1'b0;
        bus.m_BREADY   = 1'b0;
        if (state != IDLE) grant[owner] = 1'b1;
        unique case (state)
            IDLE: begin
                if (|pickGnt) stateNxt = ADDR;
            end
            ADDR: begin
                bus.m_AWVALID        = bus.s_AWVALID[owner];
                bus.m_AWADDR         = bus.s_AWADDR[int'(owner)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                bus.m_AWLEN          = bus.s_AWLEN[int'(owner)*8 +: 8];
                bus.s_AWREADY[owner] = bus.m_AWREADY;
                if (bus.s_AWVALID[owner] && bus.m_AWREADY) stateNxt = DATA;
            end
            DATA: begin
                bus.m_WVALID        = bus.s_WVALID[owner];
                bus.m_WLAST         = bus.s_WLAST[owner];
                bus.m_WDATA         = bus.s_WDATA[int'(owner)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                bus.s_WREADY[owner] = bus.m_WREADY;
                if (bus.s_WVALID[owner] && bus.m_WREADY && bus.s_WLAST[owner]) stateNxt = RESP;
            end
            RESP: begin
                bus.m_BREADY                  = 1'b1;
                bus.s_BVALID[owner]           = bus.m_BVALID;
                bus.s_BRESP[{owner, 1'b0} +: 2] = bus.m_BRESP;
                if (bus.m_BVALID) begin
                    stateNxt = IDLE;
                    respDone = 1'b1;
                end else if (tmrExpired) begin
                    // Synthesised SLVERR so the owner's writer can unwind a lost response.
                    bus.s_BVALID[owner]             = 1'b1;
                    bus.s_BRESP[{owner, 1'b0} +: 2] = SLVERR;
                    stateNxt                        = IDLE;
                    respDone                        = 1'b1;
                end
            end
        endcase
    end

`ifdef WFR_ARB_TIMEOUT_EN
    localparam int TmrW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmrW-1:0] tmrCnt;

    assign tmrExpired = (state == RESP) && (tmrCnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmrCnt  <= TmrW'(TIMEOUT_CYCLES);
            timeout <= 1'b0;
        end else begin
            if (state != RESP) tmrCnt <= TmrW'(TIMEOUT_CYCLES);
            else if (tmrCnt != '0) tmrCnt <= tmrCnt - TmrW'(1);
            if (tmrExpired && !bus.m_BVALID) timeout <= 1'b1;
        end
    end
`else
    logic unusedTmo;

    assign tmrExpired = 1'b0;
    assign timeout    = 1'b0;
    assign unusedTmo  = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_wfr_axi_arbiter.sv
// Directed bench for wfr_axi_arbiter: single/dual/continuous arbitration, stalls, async reset, watchdog.
module tb_wfr_axi_arbiter;

    localparam int NumM   = 4;
    localparam int AddrW  = 32;
    localparam int DataW  = 128;
    localparam int TmoCyc = 16;

    logic            sysClk = 1'b0;
    logic            rstN;
    logic [NumM-1:0] grant;
    logic            timeout;
    int              vecCnt = 0;
    int              errCnt = 0;
    logic [AddrW-1:0] addrTab [NumM];
    logic [7:0]       lenTab  [NumM];

    wfr_axi_arbiter_if #(
        .NUM_MASTERS    (NumM),
        .AXI_ADDR_WIDTH (AddrW),
        .AXI_DATA_WIDTH (DataW)
    ) bus ();

    wfr_axi_arbiter #(
        .NUM_MASTERS    (NumM),
        .AXI_ADDR_WIDTH (AddrW),
        .AXI_DATA_WIDTH (DataW),
        .TIMEOUT_CYCLES (TmoCyc)
    ) dut (
        .clk     (sysClk),
        .rst_n   (rstN),
        .bus     (bus),
        .grant   (grant),
        .timeout (timeout)
    );

    always #5 sysClk = ~sysClk;

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DataW-1:0] dataOf(input int mi, input int b);
        return {32'(mi + 1), 32'(b), 64'hC0FF_EE00_5EED_0000};
    endfunction

    task automatic clearInputs();
        bus.s_AWADDR  = '0;
        bus.s_AWLEN   = '0;
        bus.s_AWVALID = '0;
        bus.s_WDATA   = '0;
        bus.s_WLAST   = '0;
        bus.s_WVALID  = '0;
        bus.m_AWREADY = 1'b0;
        bus.m_WREADY  = 1'b0;
        bus.m_BRESP   = 2'b00;
        bus.m_BVALID  = 1'b0;
    endtask

    task automatic applyReset();
        @(negedge sysClk);
        rstN = 1'b0;
        clearInputs();
        repeat (2) @(negedge sysClk);
        rstN = 1'b1;
    endtask

    task automatic setReq(input int mi);
        bus.s_AWADDR[mi*AddrW +: AddrW] = addrTab[mi];
        bus.s_AWLEN[mi*8 +: 8]          = lenTab[mi];
        bus.s_AWVALID[mi]               = 1'b1;
    endtask

    // Serves one burst for master mi, which must be the next winner; ends in the IDLE cycle
    // after the B handshake (or in the first RESP cycle when withB is 0).
    task automatic serve(input int mi, input int awDelay, input bit wToggle, input bit keepReq,
                         input logic [1:0] resp, input bit withB);
        int waitCyc = 0;
        int b = 0;
        int t = 0;
        int len;
        logic [NumM-1:0] ownHot;
        len    = int'(lenTab[mi]);
        ownHot = NumM'(1) << mi;
        #1;
        while (bus.m_AWVALID !== 1'b1 && waitCyc < 30) begin
            @(negedge sysClk); #1;
            waitCyc++;
        end
        checkVal("aw_latency", 128'(waitCyc), 128'(1));
        checkVal("grant", grant, ownHot);
        checkVal("awaddr", bus.m_AWADDR, addrTab[mi]);
        checkVal("awlen", bus.m_AWLEN, lenTab[mi]);
        for (int d = 0; d < awDelay; d++) begin
            checkVal("awready_stall", bus.s_AWREADY, '0);
            checkVal("awvalid_hold", bus.m_AWVALID, 1'b1);
            @(negedge sysClk); #1;
        end
        bus.m_AWREADY = 1'b1;
        #1;
        checkVal("awready_owner", bus.s_AWREADY, ownHot);
        @(negedge sysClk);
        bus.m_AWREADY = 1'b0;
        if (!keepReq) bus.s_AWVALID[mi] = 1'b0;
        while (b <= len && t < 100) begin
            bus.s_WVALID[mi]                = 1'b1;
            bus.s_WDATA[mi*DataW +: DataW]  = dataOf(mi, b);
            bus.s_WLAST[mi]                 = (b == len);
            bus.m_WREADY                    = wToggle ? ((t % 2) == 1) : 1'b1;
            #1;
            checkVal("wvalid", bus.m_WVALID, 1'b1);
            checkVal("wdata", bus.m_WDATA, dataOf(mi, b));
            checkVal("wlast", bus.m_WLAST, (b == len));
            checkVal("wready_route", bus.s_WREADY, bus.m_WREADY ? ownHot : '0);
            if (bus.m_WREADY) b++;
            t++;
            @(negedge sysClk);
        end
        checkVal("beats", 128'(b), 128'(len + 1));
        bus.s_WVALID[mi] = 1'b0;
        bus.s_WLAST[mi]  = 1'b0;
        bus.m_WREADY     = 1'b0;
        #1;
        checkVal("resp_wvalid_off", bus.m_WVALID, 1'b0);
        checkVal("resp_bready", bus.m_BREADY, 1'b1);
        checkVal("resp_bvalid_wait", bus.s_BVALID, '0);
        checkVal("resp_grant", grant, ownHot);
        if (withB) begin
            @(negedge sysClk);
            bus.m_BVALID = 1'b1;
            bus.m_BRESP  = resp;
            #1;
            checkVal("bvalid_route", bus.s_BVALID, ownHot);
            checkVal("bresp_route", bus.s_BRESP, 8'(resp) << (2 * mi));
            @(negedge sysClk);
            bus.m_BVALID = 1'b0;
            bus.m_BRESP  = 2'b00;
            #1;
            checkVal("idle_grant", grant, '0);
            checkVal("idle_bvalid", bus.s_BVALID, '0);
            checkVal("idle_awvalid", bus.m_AWVALID, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        addrTab[0] = 32'h1000_0000; lenTab[0] = 8'd7;
        addrTab[1] = 32'h2000_0040; lenTab[1] = 8'd5;
        addrTab[2] = 32'h3000_0100; lenTab[2] = 8'd3;
        addrTab[3] = 32'h4000_0200; lenTab[3] = 8'd2;
        rstN = 1'b1;
        clearInputs();

        // Reset state
        applyReset();
        #1;
        checkVal("rst_grant", grant, '0);
        checkVal("rst_awvalid", bus.m_AWVALID, 1'b0);
        checkVal("rst_awaddr", bus.m_AWADDR, '0);
        checkVal("rst_wvalid", bus.m_WVALID, 1'b0);
        checkVal("rst_bready", bus.m_BREADY, 1'b0);
        checkVal("rst_awready", bus.s_AWREADY, '0);
        checkVal("rst_bvalid", bus.s_BVALID, '0);
        checkVal("rst_timeout", timeout, 1'b0);

        // Single master 0, 8 beats
        setReq(0);
        serve(0, 0, 1'b0, 1'b0, 2'b00, 1'b1);

        // Masters 0 and 2 together after reset: 0 then 2, back-to-back
        applyReset();
        setReq(0);
        setReq(2);
        serve(0, 0, 1'b0, 1'b0, 2'b00, 1'b1);
        serve(2, 0, 1'b0, 1'b0, 2'b01, 1'b1);

        // All four requesting continuously: 0,1,2,3,0,1,2,3
        applyReset();
        for (int mi = 0; mi < NumM; mi++) setReq(mi);
        for (int n = 0; n < 8; n++) begin
            if (n == 7) bus.s_AWVALID = 4'b1000;
            serve(n % 4, 0, 1'b0, (n != 7), 2'(n), 1'b1);
        end

        // WREADY toggling, AWREADY 5 cycles late, a non-owner driving W noise
        bus.s_WVALID[3]                = 1'b1;
        bus.s_WLAST[3]                 = 1'b1;
        bus.s_WDATA[3*DataW +: DataW]  = {4{32'hDEAD_BEEF}};
        setReq(1);
        serve(1, 5, 1'b1, 1'b0, 2'b01, 1'b1);
        bus.s_WVALID[3] = 1'b0;
        bus.s_WLAST[3]  = 1'b0;

        // Async reset mid-DATA, then master 0 wins over master 3
        setReq(2);
        @(negedge sysClk); #1;
        checkVal("mid_grant_addr", grant, 4'b0100);
        bus.m_AWREADY = 1'b1;
        @(negedge sysClk);
        bus.m_AWREADY    = 1'b0;
        bus.s_AWVALID[2] = 1'b0;
        bus.s_WVALID[2]  = 1'b1;
        bus.s_WDATA[2*DataW +: DataW] = dataOf(2, 0);
        bus.m_WREADY     = 1'b1;
        #1;
        checkVal("mid_in_data", bus.m_WVALID, 1'b1);
        rstN = 1'b0;
        #1;
        checkVal("mid_rst_grant", grant, '0);
        checkVal("mid_rst_wvalid", bus.m_WVALID, 1'b0);
        checkVal("mid_rst_wdata", bus.m_WDATA, '0);
        checkVal("mid_rst_wready", bus.s_WREADY, '0);
        checkVal("mid_rst_bready", bus.m_BREADY, 1'b0);
        clearInputs();
        repeat (2) @(negedge sysClk);
        rstN = 1'b1;
        setReq(3);
        setReq(0);
        serve(0, 0, 1'b0, 1'b0, 2'b00, 1'b1);
        serve(3, 0, 1'b0, 1'b0, 2'b00, 1'b1);

`ifdef WFR_ARB_TIMEOUT_EN
        begin
            int n = 0;
            setReq(1);
            serve(1, 0, 1'b0, 1'b0, 2'b00, 1'b0);
            while (bus.s_BVALID[1] !== 1'b1 && n < TmoCyc + 20) begin
                @(negedge sysClk); #1;
                n++;
            end
            checkVal("tmo_cycles", 128'(n), 128'(TmoCyc));
            checkVal("tmo_bresp", bus.s_BRESP, 8'b0000_1000);
            checkVal("tmo_bvalid", bus.s_BVALID, 4'b0010);
            @(negedge sysClk); #1;
            checkVal("tmo_flag", timeout, 1'b1);
            checkVal("tmo_idle_grant", grant, '0);
            checkVal("tmo_pulse_end", bus.s_BVALID, '0);
            setReq(2);
            serve(2, 0, 1'b0, 1'b0, 2'b00, 1'b1);
            checkVal("tmo_sticky", timeout, 1'b1);
        end
`else
        checkVal("tmo_tied_off", timeout, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
